// File: rtl/sensor_frontend.sv
// Home-controller sensor front end: three synchronized/debounced contacts plus a
// serial temperature reader. Define TEMP_RANGE_CHECK_EN to reject readings above 100 C.
module sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCK_DIV         = 4,
  parameter int SAMPLE_PERIOD   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       motion_raw,
  input  logic       light_raw,
  input  logic       override_raw,
  input  logic       temp_sdo,
  output logic       temp_cs_n,
  output logic       temp_sck,
  output logic       motion_sensor,
  output logic       light_sensor,
  output logic       manual_override,
  output logic [7:0] temp_sensor,
  output logic       temp_valid,
  output logic       temp_err,
  output logic [1:0] dbg_state
);

  localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  DIV_LAST   = 8'(SCK_DIV - 1);
  localparam logic [15:0] TIMER_LAST = 16'(SAMPLE_PERIOD - 1);

  // ---------------- contact synchronizers and debouncers ----------------
  logic [2:0] raw_vec;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] deb_q;

  assign raw_vec = {override_raw, light_raw, motion_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [7:0] cnt_q;

    // Output flips only after DEBOUNCE_CYCLES consecutive disagreeing clocks.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q    <= '0;
        deb_q[g] <= 1'b0;
      end else if (sync2_q[g] != deb_q[g]) begin
        if (cnt_q == DEB_LAST) begin
          cnt_q    <= '0;
          deb_q[g] <= ~deb_q[g];
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign motion_sensor   = deb_q[0];
  assign light_sensor    = deb_q[1];
  assign manual_override = deb_q[2];

  // ---------------- temperature conversion FSM ----------------
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  half_q, half_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  temp_q, temp_d;
  logic        valid_q, valid_d;
`ifdef TEMP_RANGE_CHECK_EN
  logic        err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      div_q   <= '0;
      half_q  <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      shreg_q <= '0;
      temp_q  <= '0;
      valid_q <= 1'b0;
`ifdef TEMP_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      shreg_q <= shreg_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
`ifdef TEMP_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    div_d   = div_q;
    half_d  = half_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    shreg_d = shreg_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
`ifdef TEMP_RANGE_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          div_d   = '0;
          cs_n_d  = 1'b0;
          state_d = SETUP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        // 16 half-periods; data is captured on the clk that raises temp_sck.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) shreg_d = {shreg_q[6:0], temp_sdo};
          if (half_q == 4'd15) begin
            cs_n_d  = 1'b1;
            state_d = DONE;
          end else begin
            half_d = half_q + 4'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        cs_n_d  = 1'b1;
        timer_d = '0;
        state_d = IDLE;
`ifdef TEMP_RANGE_CHECK_EN
        if (shreg_q > 8'd100) begin
          err_d = 1'b1;
        end else begin
          temp_d  = shreg_q;
          valid_d = 1'b1;
        end
`else
        temp_d  = shreg_q;
        valid_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign temp_cs_n   = cs_n_q;
  assign temp_sck    = sck_q;
  assign temp_sensor = temp_q;
  assign temp_valid  = valid_q;
  assign dbg_state   = state_q;
`ifdef TEMP_RANGE_CHECK_EN
  assign temp_err    = err_q;
`else
  assign temp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed bench for sensor_frontend with a behavioural serial temperature sensor.
// Clock numbers below count rising edges since the last reset release.
module tb_sensor_frontend;

  localparam int D  = 4;
  localparam int SD = 2;
  localparam int SP = 50;
`ifdef TEMP_RANGE_CHECK_EN
  localparam int EXP_VALIDS = 2;
`else
  localparam int EXP_VALIDS = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       motion_raw = 1'b0;
  logic       light_raw = 1'b0;
  logic       override_raw = 1'b0;
  logic       temp_sdo = 1'b0;
  logic       temp_cs_n, temp_sck;
  logic       motion_sensor, light_sensor, manual_override;
  logic [7:0] temp_sensor;
  logic       temp_valid, temp_err;
  logic [1:0] dbg_state;

  logic [7:0] sensor_val = 8'd0;
  int         bit_idx = 7;
  int         rise_cnt = 0;
  int         vcnt = 0;
  int         cyc_n = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  sensor_frontend #(.DEBOUNCE_CYCLES(D), .SCK_DIV(SD), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst(rst),
    .motion_raw(motion_raw), .light_raw(light_raw), .override_raw(override_raw),
    .temp_sdo(temp_sdo), .temp_cs_n(temp_cs_n), .temp_sck(temp_sck),
    .motion_sensor(motion_sensor), .light_sensor(light_sensor),
    .manual_override(manual_override), .temp_sensor(temp_sensor),
    .temp_valid(temp_valid), .temp_err(temp_err), .dbg_state(dbg_state)
  );

  // clock / reset-relative cycle counter
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc_n <= 0;
    else      cyc_n <= cyc_n + 1;
  end

  always @(negedge clk) if (temp_valid) vcnt <= vcnt + 1;

  // sensor model: MSB presented at chip-select, next bit after each sck rise
  always @(negedge temp_cs_n or posedge temp_sck) begin
    if (temp_sck == 1'b0) begin
      bit_idx  = 7;
      rise_cnt = 0;
      temp_sdo = sensor_val[7];
    end else if (temp_cs_n == 1'b0) begin
      rise_cnt = rise_cnt + 1;
      if (bit_idx > 0) bit_idx = bit_idx - 1;
      temp_sdo = sensor_val[bit_idx];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc_n < n) @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n", temp_cs_n, 1);
    chk("rst_sck", temp_sck, 0);
    chk("rst_temp", temp_sensor, 0);
    chk("rst_valid", temp_valid, 0);
    chk("rst_err", temp_err, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_deb", {motion_sensor, light_sensor, manual_override}, 0);
    rst = 1'b1;

    // conversion 0: sensor returns 0
    wait_cyc(49);  chk("c0_cs_before", temp_cs_n, 1);
    wait_cyc(50);  chk("c0_cs_fall", temp_cs_n, 0);
                   chk("c0_setup", dbg_state, 1);
    wait_cyc(52);  chk("c0_shift", dbg_state, 2);
                   chk("c0_sck_low", temp_sck, 0);
    wait_cyc(54);  chk("c0_sck_rise", temp_sck, 1);
    wait_cyc(84);  chk("c0_done", dbg_state, 3);
                   chk("c0_done_cs", temp_cs_n, 1);
                   chk("c0_done_sck", temp_sck, 0);
                   chk("c0_valid_early", temp_valid, 0);
    wait_cyc(85);  chk("c0_valid", temp_valid, 1);
                   chk("c0_temp", temp_sensor, 0);
                   chk("c0_err", temp_err, 0);
                   chk("c0_idle", dbg_state, 0);
    wait_cyc(86);  chk("c0_valid_drop", temp_valid, 0);

    // conversion 1: sensor returns 31
    sensor_val = 8'd31;
    wait_cyc(134); chk("c1_cs_before", temp_cs_n, 1);
    wait_cyc(135); chk("c1_cs_fall", temp_cs_n, 0);
    wait_cyc(169); chk("c1_valid_early", temp_valid, 0);
    wait_cyc(170); chk("c1_valid", temp_valid, 1);
                   chk("c1_temp", temp_sensor, 31);
                   chk("c1_rises", rise_cnt, 8);
    wait_cyc(171); chk("c1_valid_drop", temp_valid, 0);
                   chk("c1_hold", temp_sensor, 31);

    // clean motion edge: 6 clocks to the output
    motion_raw = 1'b1;
    wait_cyc(176); chk("mot_rise_early", motion_sensor, 0);
    wait_cyc(177); chk("mot_rise", motion_sensor, 1);

    // 3-clock light glitch is filtered
    wait_cyc(180); light_raw = 1'b1;
    wait_cyc(183); light_raw = 1'b0;
    wait_cyc(186); chk("light_glitch_a", light_sensor, 0);
    wait_cyc(192); chk("light_glitch_b", light_sensor, 0);

    // motion release
    wait_cyc(195); motion_raw = 1'b0;
    wait_cyc(200); chk("mot_fall_early", motion_sensor, 1);
    wait_cyc(201); chk("mot_fall", motion_sensor, 0);

    // simultaneous motion and override rise
    wait_cyc(205); motion_raw = 1'b1; override_raw = 1'b1;
    wait_cyc(210); chk("both_early", {motion_sensor, manual_override}, 0);
    wait_cyc(211); chk("both_rise", {motion_sensor, manual_override}, 3);
                   chk("ovr_light", light_sensor, 0);

    // conversion 2: sensor returns 150
    wait_cyc(212); sensor_val = 8'd150;
    wait_cyc(220); chk("c2_cs_fall", temp_cs_n, 0);
    wait_cyc(255);
`ifdef TEMP_RANGE_CHECK_EN
    chk("c2_err", temp_err, 1);
    chk("c2_valid", temp_valid, 0);
    chk("c2_temp", temp_sensor, 31);
`else
    chk("c2_err", temp_err, 0);
    chk("c2_valid", temp_valid, 1);
    chk("c2_temp", temp_sensor, 150);
`endif
    chk("c2_rises", rise_cnt, 8);
    wait_cyc(256); chk("c2_err_drop", temp_err, 0);
                   chk("c2_valid_drop", temp_valid, 0);

    // conversion 3 aborted by reset in SHIFT
    sensor_val = 8'd31;
    wait_cyc(314); chk("c3_shift", dbg_state, 2);
                   chk("c3_sck_high", temp_sck, 1);
    rst = 1'b0;
    #1;
    chk("abort_cs", temp_cs_n, 1);
    chk("abort_sck", temp_sck, 0);
    chk("abort_temp", temp_sensor, 0);
    chk("abort_state", dbg_state, 0);
    chk("abort_deb", {motion_sensor, manual_override}, 0);
    repeat (3) @(negedge clk);
    chk("abort_valid", temp_valid, 0);
    rst = 1'b1;
    wait_cyc(49);  chk("r_cs_before", temp_cs_n, 1);
    wait_cyc(50);  chk("r_cs_fall", temp_cs_n, 0);
                   chk("r_no_valid", vcnt, EXP_VALIDS);
    wait_cyc(85);  chk("r_valid", temp_valid, 1);
                   chk("r_temp", temp_sensor, 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
